oled_spi_receiver: RTL and testbench

- Receive side of the 4-wire SSD1306-style serial link (sclk, sdin, cs, dc, active-low display reset) driven by the screen driver.
- Deserialises bytes MSB-first and splits command bytes from data bytes using dc.
- Parses command opcodes and their arguments into display state, and writes data bytes into a 1024-byte pixel store through a write port.
- Serves as the loopback/sink model for screen bring-up and bench checking, and as a display-emulation front end.

---
 rtl/oled_pkg.sv | 57 +++++
 rtl/spi_byte_rx.sv | 80 ++++++++
 rtl/oled_spi_receiver.sv | 162 ++++++++++++++++
 tb/tb_oled_spi_receiver.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306-style serial receiver: opcodes, decoder
// state encoding, reset defaults and opcode classification helpers.
package oled_pkg;

    localparam int          PIXEL_BYTES_DEF = 1024;
    localparam logic [7:0]  CONTRAST_RST    = 8'h7F;
    localparam logic [1:0]  ADDR_MODE_RST   = 2'b10;

    localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] OP_CONTRAST     = 8'h81;
    localparam logic [7:0] OP_ADDR_MODE    = 8'h20;
    localparam logic [7:0] OP_COL_ADDR     = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;
    localparam logic [7:0] OP_NORMAL       = 8'hA6;
    localparam logic [7:0] OP_INVERT       = 8'hA7;
    localparam logic [7:0] OP_RAM_DISPLAY  = 8'hA4;
    localparam logic [7:0] OP_ALL_ON       = 8'hA5;
    localparam logic [7:0] OP_SEG_NORMAL   = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP    = 8'hA1;
    localparam logic [7:0] OP_COM_NORMAL   = 8'hC0;
    localparam logic [7:0] OP_COM_REMAP    = 8'hC8;
    localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
    localparam logic [7:0] OP_VCOMH        = 8'hDB;
    localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_ARG1 = 2'd1,
        CMD_ARG2 = 2'd2
    } cmd_state_t;

    function automatic logic is_one_arg(input logic [7:0] op);
        return (op == OP_CONTRAST)   || (op == OP_ADDR_MODE)   ||
               (op == OP_MUX_RATIO)  || (op == OP_DISP_OFFSET) ||
               (op == OP_CLK_DIV)    || (op == OP_PRECHARGE)   ||
               (op == OP_VCOMH)      || (op == OP_CHARGE_PUMP);
    endfunction

    function automatic logic is_two_arg(input logic [7:0] op);
        return (op == OP_COL_ADDR) || (op == OP_PAGE_ADDR);
    endfunction

    // 0x40-0x7F is the display start line family.
    function automatic logic is_single(input logic [7:0] op);
        return (op == OP_DISPLAY_OFF) || (op == OP_DISPLAY_ON)  ||
               (op == OP_NORMAL)      || (op == OP_INVERT)      ||
               (op == OP_RAM_DISPLAY) || (op == OP_ALL_ON)      ||
               (op == OP_SEG_NORMAL)  || (op == OP_SEG_REMAP)   ||
               (op == OP_COM_NORMAL)  || (op == OP_COM_REMAP)   ||
               (op[7:6] == 2'b01);
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Synchronises the serial link into clk_i, detects sclk rising edges and
// assembles MSB-first bytes; byte_valid_o is a combinational one-cycle flag.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       sclk_i,
    input  logic       sdin_i,
    input  logic       cs_i,
    input  logic       dc_i,
    input  logic       dreset_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       is_data_o,
    output logic       soft_rst_o
);

    // Bit order {dreset, dc, cs, sdin, sclk}; idle is sclk=1, cs=1, dreset=1.
    localparam logic [4:0] SYNC_IDLE = 5'b10101;

    logic [4:0] r_sync [SYNC_STAGES];
    logic [4:0] w_raw;
    logic [4:0] w_sync;
    logic       w_sclk_s;
    logic       w_sdin_s;
    logic       w_cs_s;
    logic       w_dc_s;
    logic       w_dreset_s;
    logic       r_sclk_prev;
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       w_rise;

    assign w_raw      = {dreset_i, dc_i, cs_i, sdin_i, sclk_i};
    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_sclk_s   = w_sync[0];
    assign w_sdin_s   = w_sync[1];
    assign w_cs_s     = w_sync[2];
    assign w_dc_s     = w_sync[3];
    assign w_dreset_s = w_sync[4];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= SYNC_IDLE;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Edges are only honoured while selected and out of display reset.
    assign w_rise = w_sclk_s && !r_sclk_prev && !w_cs_s && w_dreset_s;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sclk_prev <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            if (w_cs_s || !w_dreset_s) begin
                r_bit_cnt <= '0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[5:0], w_sdin_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    assign byte_valid_o = w_rise && (r_bit_cnt == 3'd7);
    assign byte_o       = {r_shift, w_sdin_s};
    assign is_data_o    = w_dc_s;
    assign soft_rst_o   = !w_dreset_s;

endmodule

// File: rtl/oled_spi_receiver.sv
// Display-side model of the SSD1306 serial link: decodes command bytes into
// display state and streams data bytes into a wrapping pixel write port.
module oled_spi_receiver
    import oled_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PIXEL_BYTES = PIXEL_BYTES_DEF,
    parameter int ADDR_W      = 10
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              io_sclk_i,
    input  logic              io_sdin_i,
    input  logic              io_cs_i,
    input  logic              io_dc_i,
    input  logic              io_reset_i,
    output logic              cmd_valid_o,
    output logic [7:0]        cmd_byte_o,
    output logic              pix_we_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [7:0]        pix_data_o,
    output logic              display_on_o,
    output logic [7:0]        contrast_o,
    output logic              invert_o,
    output logic [1:0]        addr_mode_o,
    output logic              charge_pump_o,
    output logic              unknown_cmd_o
);

    logic              w_byte_valid;
    logic [7:0]        w_byte;
    logic              w_is_data;
    logic              w_soft_rst;
    logic [ADDR_W-1:0] w_ptr_next;

    cmd_state_t        r_state;
    logic [7:0]        r_opcode;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_cmd_valid;
    logic [7:0]        r_cmd_byte;
    logic              r_pix_we;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [7:0]        r_pix_data;
    logic              r_display_on;
    logic [7:0]        r_contrast;
    logic              r_invert;
    logic [1:0]        r_addr_mode;
    logic              r_charge_pump;
    logic              r_unknown;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .sclk_i       (io_sclk_i),
        .sdin_i       (io_sdin_i),
        .cs_i         (io_cs_i),
        .dc_i         (io_dc_i),
        .dreset_i     (io_reset_i),
        .byte_valid_o (w_byte_valid),
        .byte_o       (w_byte),
        .is_data_o    (w_is_data),
        .soft_rst_o   (w_soft_rst)
    );

    assign w_ptr_next = (r_ptr == ADDR_W'(PIXEL_BYTES - 1)) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= CMD_IDLE;
            r_opcode      <= '0;
            r_ptr         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_byte    <= '0;
            r_pix_we      <= 1'b0;
            r_pix_addr    <= '0;
            r_pix_data    <= '0;
            r_display_on  <= 1'b0;
            r_contrast    <= CONTRAST_RST;
            r_invert      <= 1'b0;
            r_addr_mode   <= ADDR_MODE_RST;
            r_charge_pump <= 1'b0;
            r_unknown     <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_pix_we    <= 1'b0;
            if (w_soft_rst) begin
                r_state       <= CMD_IDLE;
                r_opcode      <= '0;
                r_ptr         <= '0;
                r_display_on  <= 1'b0;
                r_contrast    <= CONTRAST_RST;
                r_invert      <= 1'b0;
                r_addr_mode   <= ADDR_MODE_RST;
                r_charge_pump <= 1'b0;
                r_unknown     <= 1'b0;
            end else if (w_byte_valid && w_is_data) begin
                // A data byte also cancels any half-received command.
                r_pix_we   <= 1'b1;
                r_pix_addr <= r_ptr;
                r_pix_data <= w_byte;
                r_ptr      <= w_ptr_next;
                r_state    <= CMD_IDLE;
            end else if (w_byte_valid) begin
                r_cmd_valid <= 1'b1;
                r_cmd_byte  <= w_byte;
                case (r_state)
                    CMD_IDLE: begin
                        if (is_one_arg(w_byte)) begin
                            r_opcode <= w_byte;
                            r_state  <= CMD_ARG1;
                        end else if (is_two_arg(w_byte)) begin
                            r_opcode <= w_byte;
                            r_state  <= CMD_ARG2;
                        end else if (w_byte == OP_DISPLAY_OFF) begin
                            r_display_on <= 1'b0;
                        end else if (w_byte == OP_DISPLAY_ON) begin
                            r_display_on <= 1'b1;
                        end else if (w_byte == OP_NORMAL) begin
                            r_invert <= 1'b0;
                        end else if (w_byte == OP_INVERT) begin
                            r_invert <= 1'b1;
                        end else if (!is_single(w_byte)) begin
                            r_unknown <= 1'b1;
                        end
                    end
                    CMD_ARG2: begin
                        r_state <= CMD_ARG1;
                    end
                    CMD_ARG1: begin
                        r_state <= CMD_IDLE;
                        case (r_opcode)
                            OP_CONTRAST:    r_contrast    <= w_byte;
                            OP_ADDR_MODE:   r_addr_mode   <= w_byte[1:0];
                            OP_CHARGE_PUMP: r_charge_pump <= w_byte[2];
                            OP_COL_ADDR,
                            OP_PAGE_ADDR:   r_ptr         <= '0;
                            default:        ;
                        endcase
                    end
                    default: begin
                        r_state <= CMD_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_valid_o   = r_cmd_valid;
    assign cmd_byte_o    = r_cmd_byte;
    assign pix_we_o      = r_pix_we;
    assign pix_addr_o    = r_pix_addr;
    assign pix_data_o    = r_pix_data;
    assign display_on_o  = r_display_on;
    assign contrast_o    = r_contrast;
    assign invert_o      = r_invert;
    assign addr_mode_o   = r_addr_mode;
    assign charge_pump_o = r_charge_pump;
    assign unknown_cmd_o = r_unknown;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: a command table plus hand-written
// sequences for pixel streaming, partial bytes, aborts and both resets.
module tb_oled_spi_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int PIXEL_BYTES = 1024;
    localparam int ADDR_W      = 10;
    localparam int LAT         = SYNC_STAGES + 1;

    logic              clk_i      = 1'b0;
    logic              reset_ni   = 1'b0;
    logic              io_sclk_i  = 1'b1;
    logic              io_sdin_i  = 1'b0;
    logic              io_cs_i    = 1'b1;
    logic              io_dc_i    = 1'b0;
    logic              io_reset_i = 1'b1;
    logic              cmd_valid_o;
    logic [7:0]        cmd_byte_o;
    logic              pix_we_o;
    logic [ADDR_W-1:0] pix_addr_o;
    logic [7:0]        pix_data_o;
    logic              display_on_o;
    logic [7:0]        contrast_o;
    logic              invert_o;
    logic [1:0]        addr_mode_o;
    logic              charge_pump_o;
    logic              unknown_cmd_o;

    oled_spi_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .PIXEL_BYTES (PIXEL_BYTES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .io_sclk_i     (io_sclk_i),
        .io_sdin_i     (io_sdin_i),
        .io_cs_i       (io_cs_i),
        .io_dc_i       (io_dc_i),
        .io_reset_i    (io_reset_i),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_byte_o    (cmd_byte_o),
        .pix_we_o      (pix_we_o),
        .pix_addr_o    (pix_addr_o),
        .pix_data_o    (pix_data_o),
        .display_on_o  (display_on_o),
        .contrast_o    (contrast_o),
        .invert_o      (invert_o),
        .addr_mode_o   (addr_mode_o),
        .charge_pump_o (charge_pump_o),
        .unknown_cmd_o (unknown_cmd_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic       disp;
        logic [7:0] contrast;
        logic       inv;
        logic [1:0] mode;
        logic       cp;
        logic       unk;
    } cmd_vec_t;

    localparam int NVEC = 18;
    cmd_vec_t vecs [NVEC];

    int                        n_tests = 0;
    int                        n_fail  = 0;
    logic [7:0]                exp_cmd_q [$];
    logic [ADDR_W+7:0]         exp_pix_q [$];
    logic [ADDR_W+7:0]         last_pix  = '0;
    int                        last_rise_cyc = 0;
    bit                        chk_lat = 1'b0;
    logic [ADDR_W-1:0]         ptr = '0;

    // Scoreboard: every strobe is matched against the head of its queue.
    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (cmd_valid_o && pix_we_o) begin
                n_tests++; n_fail++;
                $display("FAIL both_strobes: cmd_valid=1 pix_we=1, required never together");
            end
            if (cmd_valid_o) begin
                n_tests++;
                if (exp_cmd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_unexpected: got 0x%02h, required no strobe", cmd_byte_o);
                end else begin
                    logic [7:0] e;
                    e = exp_cmd_q.pop_front();
                    if (cmd_byte_o !== e) begin
                        n_fail++;
                        $display("FAIL cmd_byte: got 0x%02h, required 0x%02h", cmd_byte_o, e);
                    end
                end
            end
            if (pix_we_o) begin
                n_tests++;
                last_pix = {pix_addr_o, pix_data_o};
                if (exp_pix_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pix_unexpected: got addr %0d data 0x%02h, required no strobe",
                             pix_addr_o, pix_data_o);
                end else begin
                    logic [ADDR_W+7:0] e;
                    e = exp_pix_q.pop_front();
                    if ({pix_addr_o, pix_data_o} !== e) begin
                        n_fail++;
                        $display("FAIL pix_write: got addr %0d data 0x%02h, required addr %0d data 0x%02h",
                                 pix_addr_o, pix_data_o, e[ADDR_W+7:8], e[7:0]);
                    end
                end
            end
            if (chk_lat && (cmd_valid_o || pix_we_o)) begin
                n_tests++;
                if (cyc - last_rise_cyc != LAT) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, required %0d", cyc - last_rise_cyc, LAT);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            io_sclk_i = 1'b0;
            io_sdin_i = b[i];
            tick(1);
            io_sclk_i = 1'b1;
            last_rise_cyc = cyc;
            tick(1);
        end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        io_dc_i = d;
        send_bits(b, 8);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        exp_cmd_q.push_back(b);
        send_byte(1'b0, b);
    endtask

    task automatic send_pix(input logic [7:0] b);
        exp_pix_q.push_back({ptr, b});
        ptr = ptr + 1'b1;
        send_byte(1'b1, b);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_cmd_q.size() != 0 || exp_pix_q.size() != 0) && t < 12) begin
            tick(1);
            t++;
        end
        n_tests++;
        if (exp_cmd_q.size() != 0 || exp_pix_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d cmd / %0d pix still pending, required 0",
                     name, exp_cmd_q.size(), exp_pix_q.size());
            exp_cmd_q.delete();
            exp_pix_q.delete();
        end
    endtask

    task automatic check_state(input string name, input logic disp, input logic [7:0] con,
                               input logic inv, input logic [1:0] mode, input logic cp,
                               input logic unk);
        n_tests++;
        if (display_on_o !== disp || contrast_o !== con || invert_o !== inv ||
            addr_mode_o !== mode || charge_pump_o !== cp || unknown_cmd_o !== unk) begin
            n_fail++;
            $display("FAIL %s: got on=%b con=0x%02h inv=%b mode=%0d cp=%b unk=%b, required on=%b con=0x%02h inv=%b mode=%0d cp=%b unk=%b",
                     name, display_on_o, contrast_o, invert_o, addr_mode_o, charge_pump_o,
                     unknown_cmd_o, disp, con, inv, mode, cp, unk);
        end
    endtask

    initial begin
        vecs[0]  = '{8'hAE, 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[1]  = '{8'h81, 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[2]  = '{8'h7F, 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[3]  = '{8'hA6, 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{8'h20, 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 8'h7F, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[6]  = '{8'h8D, 1'b0, 8'h7F, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{8'h14, 1'b0, 8'h7F, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{8'hAF, 1'b1, 8'h7F, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[9]  = '{8'hA7, 1'b1, 8'h7F, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[10] = '{8'h81, 1'b1, 8'h7F, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{8'h33, 1'b1, 8'h33, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{8'h20, 1'b1, 8'h33, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[13] = '{8'h01, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[14] = '{8'h8D, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{8'h10, 1'b1, 8'h33, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[16] = '{8'hA6, 1'b1, 8'h33, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[17] = '{8'hFF, 1'b1, 8'h33, 1'b0, 2'd1, 1'b0, 1'b1};

        // Reset values, both during and after reset.
        tick(3);
        check_state("reset_held", 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0);
        n_tests++;
        if (cmd_valid_o !== 1'b0 || pix_we_o !== 1'b0 || pix_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_strobes: got cmd_valid=%b pix_we=%b addr=%0d, required 0 0 0",
                     cmd_valid_o, pix_we_o, pix_addr_o);
        end
        reset_ni = 1'b1;
        tick(3);
        check_state("reset_released", 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0);

        // Command table.
        io_cs_i = 1'b0;
        tick(1);
        for (int i = 0; i < NVEC; i++) begin
            send_cmd(vecs[i].b);
            tick(4);
            drain($sformatf("vec%0d", i));
            check_state($sformatf("vec%0d_state", i), vecs[i].disp, vecs[i].contrast,
                        vecs[i].inv, vecs[i].mode, vecs[i].cp, vecs[i].unk);
        end

        // Data bytes with cs pulsed between them; strobe latency checked.
        chk_lat = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            io_cs_i = 1'b0;
            tick(1);
            send_pix(8'(k));
            tick(1);
            io_cs_i = 1'b1;
            tick(4);
        end
        drain("pix_cs_pulsed");
        chk_lat = 1'b0;

        // Partial byte dropped by cs high, then a clean argument.
        io_cs_i = 1'b0;
        tick(1);
        send_cmd(8'h81);
        io_dc_i = 1'b0;
        send_bits(8'hA5, 4);
        io_cs_i = 1'b1;
        tick(3);
        io_cs_i = 1'b0;
        tick(1);
        send_cmd(8'h40);
        tick(4);
        drain("partial");
        check_state("partial_state", 1'b1, 8'h40, 1'b0, 2'd1, 1'b0, 1'b1);

        // Data byte aborts a pending 0x81; 0x7F afterwards must not be an argument.
        send_cmd(8'h81);
        send_pix(8'h55);
        send_cmd(8'h7F);
        tick(4);
        drain("abort");
        check_state("abort_state", 1'b1, 8'h40, 1'b0, 2'd1, 1'b0, 1'b1);

        // Column address resets the pointer, then a full wrap of the pixel space.
        send_cmd(8'h21);
        send_cmd(8'h00);
        send_cmd(8'h7F);
        ptr = '0;
        for (int i = 1; i <= PIXEL_BYTES + 1; i++) begin
            send_pix(8'(i));
        end
        tick(4);
        drain("wrap");
        n_tests++;
        if (last_pix !== {10'd0, 8'h01}) begin
            n_fail++;
            $display("FAIL wrap_last: got addr %0d data 0x%02h, required addr 0 data 0x01",
                     last_pix[ADDR_W+7:8], last_pix[7:0]);
        end

        // Display soft reset.
        for (int i = 0; i < 10; i++) begin
            send_pix(8'(8'hA0 + i));
        end
        send_cmd(8'hAF);
        tick(4);
        drain("pre_soft_reset");
        check_state("pre_soft_reset_state", 1'b1, 8'h40, 1'b0, 2'd1, 1'b0, 1'b1);
        io_reset_i = 1'b0;
        tick(3);
        io_reset_i = 1'b1;
        tick(4);
        check_state("soft_reset_state", 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0);
        ptr = '0;
        send_pix(8'hC3);
        tick(4);
        drain("post_soft_reset");

        // Asynchronous reset mid-byte: no strobe, clean restart afterwards.
        send_cmd(8'hAF);
        tick(4);
        drain("pre_async");
        io_dc_i = 1'b0;
        send_bits(8'hA7, 4);
        reset_ni = 1'b0;
        tick(2);
        check_state("async_reset_state", 1'b0, 8'h7F, 1'b0, 2'd2, 1'b0, 1'b0);
        reset_ni = 1'b1;
        io_cs_i  = 1'b1;
        tick(6);
        io_cs_i = 1'b0;
        tick(1);
        send_cmd(8'hA7);
        tick(4);
        drain("post_async");
        check_state("post_async_state", 1'b0, 8'h7F, 1'b1, 2'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
